// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: internal pixel strobe, sync/DE generation and
// RGB565 output from built-in test patterns or an external pixel source.
module vga_timing_gen #(
  parameter int CLK_DIV  = 4,
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int CW       = 12
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic [15:0]   ext_rgb,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic          pix_ce,
  output logic          frame_start,
  output logic          vga_hs,
  output logic          vga_vs,
  output logic          vga_de,
  output logic [4:0]    vga_r,
  output logic [5:0]    vga_g,
  output logic [4:0]    vga_b
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DW      = $clog2(CLK_DIV);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] H_EDGE   = CW'(H_ACTIVE - 1);
  localparam logic [CW-1:0] V_EDGE   = CW'(V_ACTIVE - 1);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] BAR_W    = CW'(H_ACTIVE / 8);

  localparam logic [1:0] MODE_EXT  = 2'b00;
  localparam logic [1:0] MODE_BARS = 2'b01;
  localparam logic [1:0] MODE_GRID = 2'b10;
  localparam logic [1:0] MODE_BLUE = 2'b11;

  logic [DW-1:0] div_q, div_d;
  logic          pix_ce_q, pix_ce_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [1:0]    mode_q, mode_d, mode_eff;
  logic          fs;

  logic          de1_q, de1_d, hs1_q, hs1_d, vs1_q, vs1_d, ext1_q, ext1_d;
  logic [15:0]   rgb1_q, rgb1_d;
  logic          de2_q, de2_d, hs2_q, hs2_d, vs2_q, vs2_d;
  logic [15:0]   rgb2_q, rgb2_d;

  logic          de_now, hs_now, vs_now;
  logic [2:0]    bar_idx;
  logic [15:0]   bar_rgb, pattern;

  // The new mode must already apply to pixel (0,0) of the frame that samples it.
  assign fs       = pix_ce_q && (x_q == '0) && (y_q == '0);
  assign mode_eff = fs ? mode : mode_q;

  always_comb begin
    div_d    = div_q + DW'(1);
    pix_ce_d = 1'b0;
    if (div_q == DIV_LAST) begin
      div_d    = '0;
      pix_ce_d = 1'b1;
    end
    x_d    = x_q;
    y_d    = y_q;
    mode_d = mode_q;
    if (pix_ce_q) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end
      if (fs) mode_d = mode;
    end
  end

  always_comb begin
    bar_idx = 3'(x_q / BAR_W);
    case (bar_idx)
      3'd0:    bar_rgb = 16'hFFFF;
      3'd1:    bar_rgb = 16'hFFE0;
      3'd2:    bar_rgb = 16'h07FF;
      3'd3:    bar_rgb = 16'h07E0;
      3'd4:    bar_rgb = 16'hF81F;
      3'd5:    bar_rgb = 16'hF800;
      3'd6:    bar_rgb = 16'h001F;
      default: bar_rgb = 16'h0000;
    endcase
    pattern = '0;
    case (mode_eff)
      MODE_BARS: pattern = bar_rgb;
      MODE_GRID: pattern = ((x_q[4:0] == 5'd0) || (y_q[4:0] == 5'd0) ||
                            (x_q == H_EDGE) || (y_q == V_EDGE)) ? 16'hFFFF : 16'h0000;
      MODE_BLUE: pattern = 16'h001F;
      default:   pattern = '0;
    endcase
  end

  // External pixels arrive one tick after their coordinate, so they join at stage 2
  // alongside the stage-1 timing of the same coordinate.
  always_comb begin
    de_now = (x_q < H_ACT) && (y_q < V_ACT);
    hs_now = (x_q >= HS_START) && (x_q < HS_END);
    vs_now = (y_q >= VS_START) && (y_q < VS_END);
    de1_d  = de1_q;
    hs1_d  = hs1_q;
    vs1_d  = vs1_q;
    ext1_d = ext1_q;
    rgb1_d = rgb1_q;
    de2_d  = de2_q;
    hs2_d  = hs2_q;
    vs2_d  = vs2_q;
    rgb2_d = rgb2_q;
    if (pix_ce_q) begin
      de1_d  = de_now;
      hs1_d  = hs_now ? HS_POL : ~HS_POL;
      vs1_d  = vs_now ? VS_POL : ~VS_POL;
      ext1_d = (mode_eff == MODE_EXT);
      rgb1_d = de_now ? pattern : '0;
      de2_d  = de1_q;
      hs2_d  = hs1_q;
      vs2_d  = vs1_q;
      rgb2_d = ext1_q ? (de1_q ? ext_rgb : '0) : rgb1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q    <= '0;
      pix_ce_q <= 1'b0;
      x_q      <= '0;
      y_q      <= '0;
      mode_q   <= MODE_BARS;
      de1_q    <= 1'b0;
      hs1_q    <= ~HS_POL;
      vs1_q    <= ~VS_POL;
      ext1_q   <= 1'b0;
      rgb1_q   <= '0;
      de2_q    <= 1'b0;
      hs2_q    <= ~HS_POL;
      vs2_q    <= ~VS_POL;
      rgb2_q   <= '0;
    end else begin
      div_q    <= div_d;
      pix_ce_q <= pix_ce_d;
      x_q      <= x_d;
      y_q      <= y_d;
      mode_q   <= mode_d;
      de1_q    <= de1_d;
      hs1_q    <= hs1_d;
      vs1_q    <= vs1_d;
      ext1_q   <= ext1_d;
      rgb1_q   <= rgb1_d;
      de2_q    <= de2_d;
      hs2_q    <= hs2_d;
      vs2_q    <= vs2_d;
      rgb2_q   <= rgb2_d;
    end
  end

  assign pix_x       = x_q;
  assign pix_y       = y_q;
  assign pix_ce      = pix_ce_q;
  assign frame_start = fs;
  assign vga_hs      = hs2_q;
  assign vga_vs      = vs2_q;
  assign vga_de      = de2_q;
  assign vga_r       = rgb2_q[15:11];
  assign vga_g       = rgb2_q[10:5];
  assign vga_b       = rgb2_q[4:0];

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: a 640x480 instance for reset/line timing and
// a tiny 14x7 instance for whole-frame, mode-change and external-pixel checks.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        rst_a, rst_b;
  logic [1:0]  mode_a, mode_b;
  logic [15:0] ext_a, ext_b;
  logic [11:0] pix_x_a, pix_y_a, pix_x_b, pix_y_b;
  logic        pix_ce_a, fs_a, hs_a, vs_a, de_a;
  logic        pix_ce_b, fs_b, hs_b, vs_b, de_b;
  logic [4:0]  r_a, b_a, r_b, b_b;
  logic [5:0]  g_a, g_b;
  logic [15:0] rgb_a, rgb_b;
  logic [15:0] ext_cap;

  assign rgb_a = {r_a, g_a, b_a};
  assign rgb_b = {r_b, g_b, b_b};

  vga_timing_gen dut_a (
    .clk(clk), .reset(rst_a), .mode(mode_a), .ext_rgb(ext_a),
    .pix_x(pix_x_a), .pix_y(pix_y_a), .pix_ce(pix_ce_a), .frame_start(fs_a),
    .vga_hs(hs_a), .vga_vs(vs_a), .vga_de(de_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
  );

  vga_timing_gen #(
    .CLK_DIV(2), .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .CW(12)
  ) dut_b (
    .clk(clk), .reset(rst_b), .mode(mode_b), .ext_rgb(ext_b),
    .pix_x(pix_x_b), .pix_y(pix_y_b), .pix_ce(pix_ce_b), .frame_start(fs_b),
    .vga_hs(hs_b), .vga_vs(vs_b), .vga_de(de_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
  );

  function automatic logic [15:0] ext_val(input logic [11:0] x, input logic [11:0] y);
    return {y[4:0], x[5:0], y[4:0]};
  endfunction

  // Hand-written expectations for the 14x7 instance: {de, hs, vs, rgb}.
  function automatic logic [18:0] exp_b(input logic [1:0] m, input int x, input int y);
    logic de, hs, vs;
    logic [15:0] rgb;
    de  = (x < 8) && (y < 4);
    hs  = (x == 10) || (x == 11);
    vs  = (y != 5);
    rgb = 16'h0000;
    if (de) begin
      case (m)
        2'b01: case (x)
                 0: rgb = 16'hFFFF;  1: rgb = 16'hFFE0;
                 2: rgb = 16'h07FF;  3: rgb = 16'h07E0;
                 4: rgb = 16'hF81F;  5: rgb = 16'hF800;
                 6: rgb = 16'h001F;  default: rgb = 16'h0000;
               endcase
        2'b10: rgb = (x == 0 || y == 0 || x == 7 || y == 3) ? 16'hFFFF : 16'h0000;
        2'b11: rgb = 16'h001F;
        default: rgb = ext_val(12'(x), 12'(y));
      endcase
    end
    return {de, hs, vs, rgb};
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic goto_a(input int x, input int y);
    bit hit = 1'b0;
    for (int n = 0; n < 5000 && !hit; n++) begin
      @(negedge clk);
      if (pix_ce_a && pix_x_a == 12'(x) && pix_y_a == 12'(y)) hit = 1'b1;
    end
    check_output($sformatf("reach_a_%0d_%0d", x, y), 32'(hit), 1);
  endtask

  task automatic goto_b(input int x, input int y);
    bit hit = 1'b0;
    for (int n = 0; n < 1000 && !hit; n++) begin
      @(negedge clk);
      if (pix_ce_b && pix_x_b == 12'(x) && pix_y_b == 12'(y)) hit = 1'b1;
    end
    check_output($sformatf("reach_b_%0d_%0d", x, y), 32'(hit), 1);
  endtask

  task automatic next_ce_b();
    bit hit = 1'b0;
    for (int n = 0; n < 10 && !hit; n++) begin
      @(negedge clk);
      if (pix_ce_b) hit = 1'b1;
    end
    if (!hit) check_output("ce_b_timeout", 32'(hit), 1);
  endtask

  task automatic release_a(input string tag);
    @(negedge clk);
    rst_a = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      check_output($sformatf("%s_ce_clk%0d", tag, i), 32'(pix_ce_a), 32'(i == 4));
    end
    check_output({tag, "_fs"}, 32'(fs_a), 1);
    check_output({tag, "_x"}, 32'(pix_x_a), 0);
  endtask

  // Entered on the tick showing coordinate (2,0); checks the 98 pixels of one frame.
  task automatic apply_stimulus_frame(input logic [1:0] m, input int chg_p,
                                      input logic [1:0] chg_m, input string tag);
    int de_n = 0;
    int hs_n = 0;
    int vs_n = 0;
    for (int p = 0; p < 98; p++) begin
      check_output($sformatf("%s_p%0d", tag, p), 32'({de_b, hs_b, vs_b, rgb_b}),
                   32'(exp_b(m, p % 14, p / 14)));
      de_n += int'(de_b);
      hs_n += int'(hs_b);
      vs_n += int'(!vs_b);
      if (p == chg_p) mode_b = chg_m;
      next_ce_b();
    end
    check_output({tag, "_de_count"}, 32'(de_n), 32);
    check_output({tag, "_hs_count"}, 32'(hs_n), 14);
    check_output({tag, "_vs_count"}, 32'(vs_n), 14);
  endtask

  // Registered external pixel source for the small instance.
  initial begin
    ext_b = '0;
    forever begin
      @(negedge clk);
      if (pix_ce_b) begin
        ext_cap = ext_val(pix_x_b, pix_y_b);
        @(posedge clk);
        #1 ext_b = ext_cap;
      end
    end
  end

  initial begin
    int n;
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    mode_a = 2'b01;
    mode_b = 2'b01;
    ext_a  = '0;
    repeat (3) @(negedge clk);

    check_output("rst_x", 32'(pix_x_a), 0);
    check_output("rst_y", 32'(pix_y_a), 0);
    check_output("rst_ce", 32'(pix_ce_a), 0);
    check_output("rst_fs", 32'(fs_a), 0);
    check_output("rst_de", 32'(de_a), 0);
    check_output("rst_hs", 32'(hs_a), 1);
    check_output("rst_vs", 32'(vs_a), 1);
    check_output("rst_rgb", 32'(rgb_a), 0);
    check_output("rst_hs_b", 32'(hs_b), 0);

    release_a("rel1");
    @(negedge clk);
    check_output("x_after_ce", 32'(pix_x_a), 1);
    check_output("ce_single", 32'(pix_ce_a), 0);

    goto_a(2, 0);
    check_output("bar_x0", 32'({de_a, rgb_a}), 32'h1FFFF);
    goto_a(81, 0);
    check_output("bar_x79", 32'(rgb_a), 32'hFFFF);
    goto_a(82, 0);
    check_output("bar_x80", 32'(rgb_a), 32'hFFE0);
    goto_a(402, 0);
    check_output("bar_x400", 32'(rgb_a), 32'hF800);
    goto_a(562, 0);
    check_output("bar_x560", 32'({de_a, rgb_a}), 32'h10000);
    goto_a(642, 0);
    check_output("blank_x640", 32'({de_a, rgb_a}), 0);
    goto_a(657, 0);
    check_output("hs_x655", 32'(hs_a), 1);
    goto_a(658, 0);
    check_output("hs_x656", 32'(hs_a), 0);
    goto_a(753, 0);
    check_output("hs_x751", 32'(hs_a), 0);
    goto_a(754, 0);
    check_output("hs_x752", 32'(hs_a), 1);
    check_output("vs_line0", 32'(vs_a), 1);
    goto_a(799, 0);
    goto_a(0, 1);
    check_output("wrap_de", 32'(de_a), 0);
    goto_a(2, 1);
    check_output("line1_x0", 32'({de_a, rgb_a}), 32'h1FFFF);
    goto_a(300, 1);
    check_output("line1_x298", 32'(rgb_a), 32'h07E0);

    rst_a = 1'b0;
    #1;
    check_output("mid_rst_de", 32'(de_a), 0);
    check_output("mid_rst_rgb", 32'(rgb_a), 0);
    check_output("mid_rst_hs", 32'(hs_a), 1);
    check_output("mid_rst_xy", 32'({pix_x_a, pix_y_a}), 0);
    check_output("mid_rst_ce", 32'(pix_ce_a), 0);
    release_a("rel2");

    @(negedge clk);
    rst_b = 1'b1;
    goto_b(0, 0);
    check_output("b_first_fs", 32'(fs_b), 1);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (pix_ce_b) begin
        n++;
        if (fs_b) break;
      end
    end
    check_output("b_frame_period", 32'(n), 98);

    goto_b(2, 0);
    apply_stimulus_frame(2'b01, -1, 2'b01, "bars");
    apply_stimulus_frame(2'b01, 28, 2'b11, "bars_chg");
    apply_stimulus_frame(2'b11, 60, 2'b10, "blue");
    apply_stimulus_frame(2'b10, 60, 2'b00, "grid");
    apply_stimulus_frame(2'b00, -1, 2'b00, "ext");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
